// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared register-file geometry and dump-controller FSM encoding.
// Imported by the dump controller and anything else sized off the MIPS register file.
package regfile_dump_ctrl_pkg;

   localparam int RF_NUM_REGS = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Walks a spare register-file read port and streams (addr, data) beats; one beat per 2 cycles.
// out_* hold while out_valid && !out_ready; abort drops the current beat with no done pulse.
module regfile_dump_ctrl
   import regfile_dump_ctrl_pkg::*;
#(
   parameter int NUM_REGS  = RF_NUM_REGS,
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int DATA_W    = RF_DATA_W,
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR = SKIP_ZERO ? ADDR_W'(1) : '0;

   dump_state_t state, state_nxt;
   logic        handshake;
   logic        launch;

   assign handshake = out_valid & out_ready;
   // abort outranks a coincident start while idle
   assign launch    = start & ~abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (launch) state_nxt = ST_READ;
         ST_READ: state_nxt = abort ? ST_IDLE : ST_SEND;
         ST_SEND: begin
            if (abort)          state_nxt = ST_IDLE;
            else if (handshake) state_nxt = out_last ? ST_DONE : ST_READ;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   // Data is snapshotted in READ; a same-edge register-file write lands after the sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_addr   <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (launch) rf_addr <= FIRST_ADDR;
            ST_READ: begin
               if (abort) begin
                  out_valid <= 1'b0;
               end else begin
                  out_data  <= rf_data;
                  out_addr  <= rf_addr;
                  out_last  <= (rf_addr == LAST_ADDR);
                  out_valid <= 1'b1;
               end
            end
            ST_SEND: begin
               if (abort || handshake) out_valid <= 1'b0;
               // stopping at the last address means the counter can never wrap
               if (!abort && handshake && !out_last) rf_addr <= rf_addr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: two instances (SKIP_ZERO 0 and 1) reading a shared register-file model.
module tb_regfile_dump_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
   logic        start_b = 1'b0, abort_b = 1'b0, out_ready_b = 1'b1;
   logic [4:0]  rf_addr_a, rf_addr_b, out_addr_a, out_addr_b;
   logic [31:0] rf_data_a, rf_data_b, out_data_a, out_data_b;
   logic        out_valid_a, out_valid_b, out_last_a, out_last_b;
   logic        busy_a, busy_b, done_a, done_b;

   logic [31:0] rf [32];
   logic [31:0] exp_rf [32];
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (we) rf[wa] <= wd;

   assign rf_data_a = rf[rf_addr_a];
   assign rf_data_b = rf[rf_addr_b];

   regfile_dump_ctrl #(.SKIP_ZERO(1'b0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rf_addr(rf_addr_a), .rf_data(rf_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_addr(out_addr_a), .out_data(out_data_a), .out_last(out_last_a),
      .busy(busy_a), .done(done_a)
   );

   regfile_dump_ctrl #(.SKIP_ZERO(1'b1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .rf_addr(rf_addr_b), .rf_data(rf_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_addr(out_addr_b), .out_data(out_data_b), .out_last(out_last_b),
      .busy(busy_b), .done(done_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accepts beats until the done pulse (or the cycle budget runs out), checking each accepted beat.
   task automatic drain(input bit sel, input int first, output int n, output int dcnt, output int dcyc);
      logic v, r, l, d;
      logic [4:0]  a;
      logic [31:0] dt;
      n = 0; dcnt = 0; dcyc = 0;
      for (int k = 0; k < 200; k++) begin
         v  = sel ? out_valid_b : out_valid_a;
         r  = sel ? out_ready_b : out_ready;
         l  = sel ? out_last_b  : out_last_a;
         d  = sel ? done_b      : done_a;
         a  = sel ? out_addr_b  : out_addr_a;
         dt = sel ? out_data_b  : out_data_a;
         if (d) begin
            dcnt = 1;
            dcyc = cyc;
            chk("done_without_valid", 64'(v), 64'(0));
            break;
         end
         if (v && r) begin
            chk("beat_addr", 64'(a), 64'(first + n));
            chk("beat_data", 64'(dt), 64'(exp_rf[first + n]));
            chk("beat_last", 64'(l), 64'((first + n) == 31));
            n++;
         end
         tick();
      end
   endtask

   int n, dcnt, dcyc, s;
   bit found;

   initial begin
      // reset state
      tick(); tick();
      chk("rst_valid", 64'(out_valid_a), 64'(0));
      chk("rst_busy", 64'(busy_a), 64'(0));
      chk("rst_done", 64'(done_a), 64'(0));
      chk("rst_last", 64'(out_last_a), 64'(0));
      chk("rst_rf_addr", 64'(rf_addr_a), 64'(0));
      chk("rst_out", {out_addr_a, out_data_a}, 64'(0));

      // preload through the write port while still in reset
      for (int i = 0; i < 32; i++) begin
         we = 1'b1; wa = 5'(i); wd = 32'hA000_0000 + 32'(i); exp_rf[i] = wd;
         tick();
      end
      we = 1'b0;
      rst = 1'b0;
      tick();

      // full walk, ready held high
      start = 1'b1; s = cyc;
      tick(); start = 1'b0;
      chk("walk_read_valid", 64'(out_valid_a), 64'(0));
      chk("walk_read_busy", 64'(busy_a), 64'(1));
      tick();
      chk("walk_first_valid", 64'(out_valid_a), 64'(1));
      chk("walk_first_addr", 64'(out_addr_a), 64'(0));
      drain(1'b0, 0, n, dcnt, dcyc);
      chk("walk_beats", 64'(n), 64'(32));
      chk("walk_done_cnt", 64'(dcnt), 64'(1));
      // start cycle counts as cycle 1, the done cycle as cycle 66
      chk("walk_cycles", 64'(dcyc - s + 1), 64'(66));
      chk("walk_done_busy", 64'(busy_a), 64'(1));
      tick();
      chk("walk_idle_busy", 64'(busy_a), 64'(0));
      chk("walk_idle_done", 64'(done_a), 64'(0));

      // backpressure on beat 3
      start = 1'b1; tick(); start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         found = out_valid_a && out_addr_a == 5'd3;
      end
      chk("bp_reach_beat3", 64'(found), 64'(1));
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold", {31'd0, out_valid_a, out_addr_a, out_data_a[27:0]}, {31'd0, 1'b1, 5'd3, 28'h000_0003});
      end
      out_ready = 1'b1;
      tick();
      chk("bp_after_accept_valid", 64'(out_valid_a), 64'(0));
      tick();
      chk("bp_beat4", {out_valid_a, out_addr_a}, 64'({1'b1, 5'd4}));
      drain(1'b0, 4, n, dcnt, dcyc);
      chk("bp_rest_beats", 64'(n), 64'(28));
      chk("bp_done_cnt", 64'(dcnt), 64'(1));
      tick();

      // SKIP_ZERO instance
      start_b = 1'b1; tick(); start_b = 1'b0;
      tick();
      chk("skip_first", {out_valid_b, out_addr_b}, 64'({1'b1, 5'd1}));
      drain(1'b1, 1, n, dcnt, dcyc);
      chk("skip_beats", 64'(n), 64'(31));
      chk("skip_done_cnt", 64'(dcnt), 64'(1));
      tick();

      // start together with abort in IDLE
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", 64'(busy_a), 64'(0));

      // abort on beat 10 with ready high
      start = 1'b1; tick(); start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         found = out_valid_a && out_addr_a == 5'd10;
      end
      chk("abort_reach_beat10", 64'(found), 64'(1));
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_valid", 64'(out_valid_a), 64'(0));
      chk("abort_busy", 64'(busy_a), 64'(0));
      chk("abort_done", 64'(done_a), 64'(0));
      chk("abort_rf_addr", 64'(rf_addr_a), 64'(10));
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         found = found | done_a;
      end
      chk("abort_no_done", 64'(found), 64'(0));
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_rf_addr", 64'(rf_addr_a), 64'(0));
      tick();
      chk("restart_addr", {out_valid_a, out_addr_a}, 64'({1'b1, 5'd0}));
      drain(1'b0, 0, n, dcnt, dcyc);
      chk("restart_beats", 64'(n), 64'(32));
      tick();

      // start while busy, and a write to r5 at the end of its READ cycle
      start = 1'b1; tick(); start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         found = busy_a && !out_valid_a && rf_addr_a == 5'd5;
      end
      chk("snap_reach_read5", 64'(found), 64'(1));
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; start = 1'b1;
      tick();
      we = 1'b0; start = 1'b0;
      chk("snap_addr", 64'(out_addr_a), 64'(5));
      chk("snap_data", 64'(out_data_a), 64'(32'hA000_0005));
      exp_rf[5] = 32'hDEAD_BEEF;
      tick();
      drain(1'b0, 6, n, dcnt, dcyc);
      chk("busy_start_beats", 64'(n), 64'(26));
      chk("busy_start_done", 64'(dcnt), 64'(1));
      tick();

      // asynchronous reset in SEND, between edges
      start = 1'b1; tick(); start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         found = out_valid_a && out_addr_a == 5'd2;
      end
      out_ready = 1'b0;
      tick();
      chk("arst_pre_valid", 64'(out_valid_a), 64'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid_a), 64'(0));
      chk("arst_busy", 64'(busy_a), 64'(0));
      chk("arst_rf_addr", 64'(rf_addr_a), 64'(0));
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
